load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage directly downstream of the execute ALU in the RISC core. It takes the ALU result as the effective address. It performs one RV32I load or store per request over a simple req/ack data-memory bus, and returns aligned, sign- or zero-extended load data to writeback. Misaligned or illegal accesses never reach the bus; they raise a one-cycle exception pulse instead.

## Interface
- No parameters; all widths are fixed for RV32I.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  unit can accept an access (high only in IDLE)
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- addr  in  32  effective address (ALU output)
- wdata  in  32  store data (rs2)
- rd  in  5  load destination register
- mem_req  out  1  bus request; held until mem_ack
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  store data replicated into lanes
- mem_ack  in  1  bus completion; mem_rdata is valid in the same cycle
- mem_rdata  in  32  read word
- done  out  1  one-cycle pulse when an access completes
- wb_we  out  1  with done: register write required (loads with rd != 0)
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  2  0 load misaligned, 1 store misaligned, 2 illegal funct3
- exc_addr  out  32  offending addr

## Operation
- FSM states: IDLE, BUS, DONE, EXC.
- Reset value for every state and output: IDLE; all outputs 0 except req_ready = 1.
- IDLE: on req_valid && req_ready, register is_store, funct3, addr, wdata and rd, then classify the access:
  - Illegal funct3 goes to EXC, cause 2. Loads are illegal for funct3 ∈ {3,6,7}; stores are illegal for funct3 ≥ 3.
  - Misaligned access goes to EXC, cause 0 or 1. This means H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
  - Otherwise go to BUS.
  - Illegal takes priority over misaligned.
- BUS: drive mem_req = 1 with mem_addr, mem_we, mem_wstrb and mem_wdata held constant.
  - On mem_ack, loads capture mem_rdata; then go to DONE.
  - With no ack, stay in BUS indefinitely; there is no timeout.
- Store lanes:
  - B: wstrb = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: wstrb = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: wstrb = 4'hF, wdata = wdata.
- Loads drive mem_wstrb = 0 and mem_we = 0.
- Load extraction:
  - The byte is selected by addr[1:0]; the half is selected by addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- DONE: done = 1 for one cycle, wb_rd = rd, wb_data = extended data. wb_we = !is_store && rd != 0.
  - For stores, wb_data = 0.
  - Then go to IDLE.
- EXC: exc_valid = 1 for one cycle with exc_cause and exc_addr. done = 0 and wb_we = 0. Then go to IDLE.
- done, wb_we and exc_valid are never high at the same time.
- Asynchronous reset in any state returns the unit to IDLE with all outputs at their reset values.
  - mem_req drops immediately.
  - An in-flight access is abandoned, and a late mem_ack is ignored.

## Timing
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs.
- Cycle 0 accepts the request. mem_req rises in cycle 1.
- With ack in cycle N ≥ 1, done is high in cycle N+1. The next request is accepted in cycle N+2.
- Minimum latency is accept to done in 2 cycles, giving throughput of one access per 3 cycles.
- Exception path: accept in cycle 0, exc_valid in cycle 1, req_ready high again in cycle 2.
- req_ready is low in BUS, DONE and EXC. A req_valid in those states is not consumed.
- mem_ack outside BUS is ignored.

## Test plan
- LW at addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF: mem_addr = 0x100 and wstrb = 0. done in cycle 2 with wb_data = 0xDEADBEEF, wb_we = 1.
- Byte loads at addr 0x103 with rdata 0x80112233, ack delayed 3 cycles:
  - LB gives wb_data = 0xFFFFFF80.
  - LBU gives wb_data = 0x00000080.
  - mem_req is held and stable for all 3 wait cycles.
- SH at 0x202 with wdata 0x1234ABCD: mem_addr = 0x200, wstrb = 4'b1100, wdata = 0xABCDABCD, mem_we = 1. done with wb_we = 0.
- Faulting accesses never assert mem_req; exc_valid is high for exactly one cycle:
  - LW at 0x101 gives exc_cause 0, exc_addr 0x101.
  - SW with funct3 = 3 gives exc_cause 2.
- Load with rd = 0: done = 1 and wb_we = 0.
- Reset pulse during BUS, then a stray mem_ack: mem_req drops asynchronously and the state returns to IDLE. No done is issued, and the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one access from execute, classifies it, runs it
// over a req/ack data bus and returns extended load data to writeback. Faulting
// accesses are diverted to a one-cycle exception pulse and never reach the bus.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    // Request from execute
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    // Data-memory bus
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // Writeback
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    // Exceptions
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone,
        StExc
    } state_e;

    localparam logic [1:0] CauseLoadMisaligned  = 2'd0;
    localparam logic [1:0] CauseStoreMisaligned = 2'd1;
    localparam logic [1:0] CauseIllegal         = 2'd2;

    state_e      state_q, state_d;

    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;
    logic [1:0]  exc_cause_q;

    logic        accept;
    logic        req_illegal;
    logic        req_misaligned;
    logic [1:0]  req_cause;

    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [31:0] load_lane;
    logic [31:0] load_data;

    assign accept = req_valid && (state_q == StIdle);

    // Classify the incoming request; illegal encodings win over misalignment.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        req_cause      = CauseIllegal;
        if (is_store) begin
            req_illegal = (funct3 >= 3'd3);
        end else begin
            req_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        // Low two funct3 bits give the access size for both signed and unsigned forms.
        case (funct3[1:0])
            2'd1:    req_misaligned = addr[0];
            2'd2:    req_misaligned = (addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
        if (req_illegal) begin
            req_cause = CauseIllegal;
        end else if (is_store) begin
            req_cause = CauseStoreMisaligned;
        end else begin
            req_cause = CauseLoadMisaligned;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (req_illegal || req_misaligned) ? StExc : StBus;
                end
            end
            StBus: begin
                if (mem_ack) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StExc:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request at acceptance so bus signals stay stable while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            exc_cause_q <= 2'd0;
        end else if (accept) begin
            is_store_q  <= is_store;
            funct3_q    <= funct3;
            addr_q      <= addr;
            wdata_q     <= wdata;
            rd_q        <= rd;
            exc_cause_q <= req_cause;
        end
    end

    // Capture read data on the completing ack of a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if ((state_q == StBus) && mem_ack && !is_store_q) begin
            rdata_q <= mem_rdata;
        end
    end

    // Store lane placement: data replicated so every enabled lane carries it.
    always_comb begin
        store_wstrb = 4'hF;
        store_wdata = wdata_q;
        case (funct3_q[1:0])
            2'd0: begin
                store_wstrb = 4'b0001 << addr_q[1:0];
                store_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                store_wstrb = 4'b0011 << addr_q[1:0];
                store_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                store_wstrb = 4'hF;
                store_wdata = wdata_q;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend by funct3.
    always_comb begin
        load_lane = rdata_q >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    load_data = {{24{load_lane[7]}}, load_lane[7:0]};
            3'd1:    load_data = {{16{load_lane[15]}}, load_lane[15:0]};
            3'd4:    load_data = {24'd0, load_lane[7:0]};
            3'd5:    load_data = {16'd0, load_lane[15:0]};
            default: load_data = load_lane;
        endcase
    end

    // Outputs decoded from the registered state; everything idles at zero.
    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        done      = 1'b0;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        exc_valid = 1'b0;
        exc_cause = 2'd0;
        exc_addr  = 32'd0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
            end
            StBus: begin
                mem_req  = 1'b1;
                mem_we   = is_store_q;
                mem_addr = {addr_q[31:2], 2'b00};
                if (is_store_q) begin
                    mem_wstrb = store_wstrb;
                    mem_wdata = store_wdata;
                end
            end
            StDone: begin
                done    = 1'b1;
                wb_rd   = rd_q;
                wb_we   = !is_store_q && (rd_q != 5'd0);
                wb_data = is_store_q ? 32'd0 : load_data;
            end
            StExc: begin
                exc_valid = 1'b1;
                exc_cause = exc_cause_q;
                exc_addr  = addr_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses, a spec-level model of each
// access's expected bus and writeback behaviour, and a per-cycle compare process.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rd        (rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .done      (done),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .exc_valid (exc_valid),
        .exc_cause (exc_cause),
        .exc_addr  (exc_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    typedef struct packed {
        logic        is_exc;
        logic [1:0]  cause;
        logic [31:0] eaddr;
        logic [31:0] maddr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } exp_t;

    // Expected outcome of one access, from the ISA rules in plain arithmetic.
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [4:0] r,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          size;
        int          ofs;
        int          v;
        logic        legal;
        logic [31:0] lane;
        e     = '0;
        ofs   = int'(a % 32'd4);
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (!legal) begin
            e.is_exc = 1'b1;
            e.cause  = 2'd2;
            e.eaddr  = a;
        end else if ((ofs % size) != 0) begin
            e.is_exc = 1'b1;
            e.cause  = st ? 2'd1 : 2'd0;
            e.eaddr  = a;
        end else begin
            e.maddr = a - 32'(ofs);
            e.we    = st;
            e.wb_rd = r;
            if (st) begin
                e.wstrb  = 4'(((1 << size) - 1) << ofs);
                e.mwdata = (size == 1) ? wd * 32'h0101_0101 :
                           (size == 2) ? wd * 32'h0001_0001 : wd;
                if (size == 2) e.mwdata = (wd & 32'hFFFF) * 32'h0001_0001;
                if (size == 1) e.mwdata = (wd & 32'hFF) * 32'h0101_0101;
            end else begin
                lane    = rdata >> (8 * ofs);
                e.wb_we = (r != 5'd0);
                if (size == 1) begin
                    v = int'(lane & 32'hFF);
                    if (!f3[2] && v >= 128) v = v - 256;
                    e.wb_data = 32'(v);
                end else if (size == 2) begin
                    v = int'(lane & 32'hFFFF);
                    if (!f3[2] && v >= 32768) v = v - 65536;
                    e.wb_data = 32'(v);
                end else begin
                    e.wb_data = lane;
                end
            end
        end
        return e;
    endfunction

    exp_t        cur = '0;
    logic        cur_valid = 1'b0;
    logic [31:0] last_maddr = '0, last_mwdata = '0, last_wb_data = '0, last_eaddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic        last_we = 1'b0, last_wb_we = 1'b0;
    logic [1:0]  last_cause = '0;

    // Compare DUT outputs against the model every cycle (sampled on the falling edge).
    always @(negedge clk) begin
        if (rst_n) begin
            chk1("exclusive_pulses", (done & exc_valid) | (wb_we & !done), 1'b0);
            if (mem_req) begin
                if (!cur_valid || cur.is_exc) begin
                    chk1("unexpected_mem_req", mem_req, 1'b0);
                end else begin
                    chk("mem_addr", mem_addr, cur.maddr);
                    chk1("mem_we", mem_we, cur.we);
                    chk({28'd0, mem_wstrb} == 32'd0 ? "mem_wstrb" : "mem_wstrb",
                        {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.mwdata);
                    last_maddr  = mem_addr;
                    last_we     = mem_we;
                    last_wstrb  = mem_wstrb;
                    last_mwdata = mem_wdata;
                end
            end
            if (done) begin
                if (!cur_valid || cur.is_exc) begin
                    chk1("unexpected_done", done, 1'b0);
                end else begin
                    chk1("wb_we", wb_we, cur.wb_we);
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, cur.wb_rd});
                    chk("wb_data", wb_data, cur.wb_data);
                    last_wb_we   = wb_we;
                    last_wb_data = wb_data;
                end
            end
            if (exc_valid) begin
                if (!cur_valid || !cur.is_exc) begin
                    chk1("unexpected_exc", exc_valid, 1'b0);
                end else begin
                    chk("exc_cause", {30'd0, exc_cause}, {30'd0, cur.cause});
                    chk("exc_addr", exc_addr, cur.eaddr);
                    last_cause = exc_cause;
                    last_eaddr = exc_addr;
                end
            end
        end
    end

    // One access with cycle-exact handshake checks; ack arrives 'delay' cycles after mem_req rises.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r, input logic [31:0] rdata,
                          input int delay);
        @(negedge clk);
        cur       = model(st, f3, a, wd, r, rdata);
        cur_valid = 1'b1;
        chk1("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        rd        = r;
        @(posedge clk);
        #1;
        // Scramble request inputs so the unit must rely on its captured copy.
        req_valid = 1'b0;
        addr      = $urandom;
        wdata     = $urandom;
        rd        = 5'($urandom);
        funct3    = 3'($urandom);
        is_store  = 1'($urandom);
        if (cur.is_exc) begin
            @(negedge clk);
            chk1("exc_pulse", exc_valid, 1'b1);
            chk1("exc_no_mem_req", mem_req, 1'b0);
            chk1("exc_no_done", done, 1'b0);
            chk1("exc_ready_low", req_ready, 1'b0);
            @(negedge clk);
            chk1("exc_one_cycle", exc_valid, 1'b0);
            chk1("exc_no_mem_req2", mem_req, 1'b0);
            chk1("exc_ready_back", req_ready, 1'b1);
        end else begin
            for (int c = 1; c <= delay + 1; c++) begin
                @(negedge clk);
                chk1("bus_mem_req", mem_req, 1'b1);
                chk1("bus_no_done", done, 1'b0);
                chk1("bus_ready_low", req_ready, 1'b0);
                mem_ack   = (c == delay + 1);
                mem_rdata = mem_ack ? rdata : $urandom;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk1("done_pulse", done, 1'b1);
            chk1("done_mem_req_low", mem_req, 1'b0);
            chk1("done_ready_low", req_ready, 1'b0);
            @(negedge clk);
            chk1("done_one_cycle", done, 1'b0);
            chk1("done_ready_back", req_ready, 1'b1);
        end
        cur_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_exc_valid", exc_valid, 1'b0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // LW 0x100, immediate ack.
        access(1'b0, 3'd2, 32'h100, 32'd0, 5'd3, 32'hDEAD_BEEF, 0);
        chk("lw_mem_addr", last_maddr, 32'h100);
        chk("lw_wstrb", {28'd0, last_wstrb}, 32'd0);
        chk("lw_wb_data", last_wb_data, 32'hDEAD_BEEF);
        chk1("lw_wb_we", last_wb_we, 1'b1);

        // Byte loads at 0x103 with a three-cycle ack delay.
        access(1'b0, 3'd0, 32'h103, 32'd0, 5'd5, 32'h8011_2233, 3);
        chk("lb_wb_data", last_wb_data, 32'hFFFF_FF80);
        access(1'b0, 3'd4, 32'h103, 32'd0, 5'd6, 32'h8011_2233, 3);
        chk("lbu_wb_data", last_wb_data, 32'h0000_0080);

        // SH at 0x202.
        access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 5'd7, 32'd0, 1);
        chk("sh_mem_addr", last_maddr, 32'h200);
        chk("sh_wstrb", {28'd0, last_wstrb}, 32'hC);
        chk("sh_wdata", last_mwdata, 32'hABCD_ABCD);
        chk1("sh_we", last_we, 1'b1);
        chk1("sh_wb_we", last_wb_we, 1'b0);

        // Faulting accesses.
        access(1'b0, 3'd2, 32'h101, 32'd0, 5'd1, 32'd0, 0);
        chk("lw_mis_cause", {30'd0, last_cause}, 32'd0);
        chk("lw_mis_addr", last_eaddr, 32'h101);
        access(1'b1, 3'd3, 32'h40, 32'h5, 5'd1, 32'd0, 0);
        chk("sw_ill_cause", {30'd0, last_cause}, 32'd2);
        access(1'b1, 3'd1, 32'h3, 32'h5, 5'd1, 32'd0, 0);
        chk("sh_mis_cause", {30'd0, last_cause}, 32'd1);
        access(1'b1, 3'd5, 32'h1, 32'h5, 5'd1, 32'd0, 0);
        chk("st_ill_prio_cause", {30'd0, last_cause}, 32'd2);
        access(1'b0, 3'd6, 32'h8, 32'd0, 5'd1, 32'd0, 0);
        access(1'b0, 3'd3, 32'h8, 32'd0, 5'd1, 32'd0, 0);
        access(1'b0, 3'd5, 32'h1, 32'd0, 5'd1, 32'd0, 0);

        // Load to x0.
        access(1'b0, 3'd2, 32'h10, 32'd0, 5'd0, 32'h1357_9BDF, 0);
        chk1("rd0_wb_we", last_wb_we, 1'b0);

        // Half loads from the upper half, other store widths.
        access(1'b0, 3'd1, 32'h2, 32'd0, 5'd9, 32'h8001_7FFF, 2);
        chk("lh_wb_data", last_wb_data, 32'hFFFF_8001);
        access(1'b0, 3'd5, 32'h2, 32'd0, 5'd9, 32'h8001_7FFF, 0);
        chk("lhu_wb_data", last_wb_data, 32'h0000_8001);
        access(1'b0, 3'd1, 32'h0, 32'd0, 5'd9, 32'h8001_7FFF, 0);
        chk("lh_lo_wb_data", last_wb_data, 32'h0000_7FFF);
        access(1'b1, 3'd0, 32'h1, 32'h0000_00AB, 5'd2, 32'd0, 0);
        chk("sb_wstrb", {28'd0, last_wstrb}, 32'h2);
        chk("sb_wdata", last_mwdata, 32'hABAB_ABAB);
        access(1'b1, 3'd2, 32'h10, 32'hCAFE_F00D, 5'd2, 32'd0, 2);
        chk("sw_wstrb", {28'd0, last_wstrb}, 32'hF);
        chk("sw_wdata", last_mwdata, 32'hCAFE_F00D);

        // Reset during BUS, then a stray ack.
        @(negedge clk);
        cur       = model(1'b0, 3'd2, 32'h300, 32'd0, 5'd4, 32'h1111_1111);
        cur_valid = 1'b1;
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'd2;
        addr      = 32'h300;
        rd        = 5'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk1("pre_rst_mem_req", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_async_mem_req", mem_req, 1'b0);
        chk1("rst_async_ready", req_ready, 1'b1);
        cur_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("stray_ack_no_done", done, 1'b0);
        chk1("stray_ack_ready", req_ready, 1'b1);
        @(negedge clk);
        chk1("stray_ack_no_done2", done, 1'b0);

        access(1'b0, 3'd2, 32'h104, 32'd0, 5'd8, 32'h0BAD_CAFE, 1);
        chk("post_rst_lw_data", last_wb_data, 32'h0BAD_CAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
